mplier_cpa_pipe: RTL

//  Final carry-propagate stage behind the 16x16 Booth/Wallace tree. Consumes the carry-save pair
//  (a,b) and produces the binary product through a 2-stage split-adder pipeline.

---
 rtl/mplier_pkg.sv | 18 +
 rtl/mplier_cpa_slice.sv | 37 +++
 rtl/mplier_cpa_pipe.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mplier_pkg.sv
// mplier_pkg: widths and beat type shared by the multiplier tree, recoder and CPA blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: MPLIER_W (product width), MPLIER_SPLIT (CPA split point), MPLIER_TAG_W (tag width),
//           cpa_beat_t (one carry-save pair plus its sideband tag).
package mplier_pkg;

  localparam int MPLIER_W     = 32;
  localparam int MPLIER_SPLIT = 16;
  localparam int MPLIER_TAG_W = 4;

  typedef struct packed {
    logic [MPLIER_W-1:0]     a;
    logic [MPLIER_W-1:0]     b;
    logic [MPLIER_TAG_W-1:0] tag;
  } cpa_beat_t;

endpackage

// File: rtl/mplier_cpa_slice.sv
// mplier_cpa_slice: registered W-bit adder slice, {cout,sum} <= x + y + cin when en is high.
// Latency: 1 cycle from en to sum/cout.
// Backpressure: none internally; the caller stalls the slice by holding en low.
// Ports: clk, rst (sync, active-high), en (load enable), x/y (addends), cin (carry in),
//        sum (registered sum), cout (registered carry out of bit W-1).
module mplier_cpa_slice
  import mplier_pkg::*;
#(
  parameter int W = MPLIER_SPLIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] total;

  always_comb begin
    total = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (en) begin
      sum  <= total[W-1:0];
      cout <= total[W];
    end
  end

endmodule

// File: rtl/mplier_cpa_pipe.sv
// mplier_cpa_pipe: final carry-propagate add behind the Booth/Wallace tree, two-stage split adder.
// Latency: product valid 2 cycles after the accepting edge (3 if the pair parked in the skid).
// Backpressure: valid/ready both sides; without the skid in_ready is combinational from out_ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_a/in_b/in_tag (carry-save pair in);
//        out_valid/out_ready/out_product/out_cout/out_tag (binary product out).
// Build option: define MPLIER_CPA_SKID_EN to add a one-entry input skid so in_ready is a flop.
module mplier_cpa_pipe
  import mplier_pkg::*;
#(
  parameter int WIDTH = MPLIER_W,
  parameter int SPLIT = MPLIER_SPLIT,
  parameter int TAG_W = MPLIER_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_product,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag
);

  localparam int HI_W = WIDTH - SPLIT;

  // Stage 1 state: low-half sum and carry live in the slice, high halves wait here.
  logic             s1_valid;
  logic [SPLIT-1:0] s1_lo;
  logic             s1_c1;
  logic [HI_W-1:0]  s1_a_hi;
  logic [HI_W-1:0]  s1_b_hi;
  logic [TAG_W-1:0] s1_tag;

  // Output register: high half and cout come from the stage-2 slice.
  logic [HI_W-1:0]  out_hi;
  logic [SPLIT-1:0] out_lo;

  // Pair presented to stage 1 this cycle (input port or skid entry).
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [TAG_W-1:0] src_tag;

  logic out_free;   // output register empty or being drained this cycle
  logic s1_free;    // stage 1 can take a new pair this cycle
  logic s1_load;
  logic s2_adv;

  assign out_free = !out_valid || out_ready;
  assign s2_adv   = s1_valid && out_free;
  // S1 frees up either because it is empty or because its pair moves to the output register.
  assign s1_free  = !s1_valid || out_free;

`ifdef MPLIER_CPA_SKID_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_a;
  logic [WIDTH-1:0] skid_b;
  logic [TAG_W-1:0] skid_tag;
  logic             in_acc;

  assign in_ready = !skid_valid;
  assign in_acc   = in_valid && in_ready;

  // A parked pair always goes first; while it is parked in_ready is low, so nothing can overtake it.
  assign s1_load  = s1_free && (skid_valid || in_acc);
  assign src_a    = skid_valid ? skid_a   : in_a;
  assign src_b    = skid_valid ? skid_b   : in_b;
  assign src_tag  = skid_valid ? skid_tag : in_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_a     <= '0;
      skid_b     <= '0;
      skid_tag   <= '0;
    end else if (skid_valid) begin
      if (s1_free) begin
        skid_valid <= 1'b0;
      end
    end else if (in_acc && !s1_free) begin
      skid_valid <= 1'b1;
      skid_a     <= in_a;
      skid_b     <= in_b;
      skid_tag   <= in_tag;
    end
  end
`else
  assign in_ready = s1_free;
  assign s1_load  = in_valid && in_ready;
  assign src_a    = in_a;
  assign src_b    = in_b;
  assign src_tag  = in_tag;
`endif

  // Valid bits: a load always wins; otherwise a stage empties once its contents move on.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Stage 1: low-half add, high halves and tag carried forward.
  mplier_cpa_slice #(.W(SPLIT)) u_slice_lo (
    .clk  (clk),
    .rst  (rst),
    .en   (s1_load),
    .x    (src_a[SPLIT-1:0]),
    .y    (src_b[SPLIT-1:0]),
    .cin  (1'b0),
    .sum  (s1_lo),
    .cout (s1_c1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a_hi <= '0;
      s1_b_hi <= '0;
      s1_tag  <= '0;
    end else if (s1_load) begin
      s1_a_hi <= src_a[WIDTH-1:SPLIT];
      s1_b_hi <= src_b[WIDTH-1:SPLIT];
      s1_tag  <= src_tag;
    end
  end

  // Stage 2: high-half add with the stage-1 carry; writes straight into the output register.
  mplier_cpa_slice #(.W(HI_W)) u_slice_hi (
    .clk  (clk),
    .rst  (rst),
    .en   (s2_adv),
    .x    (s1_a_hi),
    .y    (s1_b_hi),
    .cin  (s1_c1),
    .sum  (out_hi),
    .cout (out_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_lo  <= '0;
      out_tag <= '0;
    end else if (s2_adv) begin
      out_lo  <= s1_lo;
      out_tag <= s1_tag;
    end
  end

  assign out_product = {out_hi, out_lo};

endmodule
